// File: rtl/spi_sample_reader.sv
// Periodic SPI frame reader: captures the 12-bit ADC sample and publishes a 2^AVG_LOG2 block average.
// Define SPI_TIMEOUT_EN to build the per-phase handshake timeout and the sticky timeout_err flag.
module spi_sample_reader #(
  parameter int PERIOD   = 100000,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        spi_d_ready,
  input  logic [15:0] spi_d,
  output logic        spi_rd,
  output logic [11:0] sample,
  output logic        sample_valid,
  output logic [11:0] avg,
  output logic        avg_valid,
  output logic        busy,
  output logic        timeout_err
);

  localparam int PCW  = $clog2(PERIOD);
  localparam int ACCW = 12 + AVG_LOG2;
  localparam int SCW  = AVG_LOG2 + 1;
  localparam logic [PCW-1:0] PER_LAST  = PCW'(PERIOD - 1);
  localparam logic [SCW-1:0] SCNT_LAST = SCW'((1 << AVG_LOG2) - 1);

  // state | meaning
  // IDLE  | waiting for the period tick
  // REQ   | spi_rd high, waiting for synchronized ready
  // CAP   | capture frame, update accumulator
  // ACK   | waiting for ready to drop
  typedef enum logic [1:0] {IDLE, REQ, CAP, ACK} state_t;

  state_t          state_q, state_d;
  logic [PCW-1:0]  pcnt_q;
  logic            tick;
  logic            rdy_meta_q, rdy_s_q;
  logic            spi_rd_q, spi_rd_d;
  logic [11:0]     sample_q, sample_d;
  logic            sval_q, sval_d;
  logic [11:0]     avg_q, avg_d;
  logic            aval_q, aval_d;
  logic [ACCW-1:0] acc_q, acc_d, acc_sum;
  logic [SCW-1:0]  scnt_q, scnt_d;
  logic            abort;
  logic            spi_hi_unused;

  assign spi_hi_unused = ^spi_d[15:12];

  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_meta_q <= 1'b0;
      rdy_s_q    <= 1'b0;
      pcnt_q     <= '0;
    end else begin
      rdy_meta_q <= spi_d_ready;
      rdy_s_q    <= rdy_meta_q;
      if (!enable || tick) pcnt_q <= '0;
      else                 pcnt_q <= pcnt_q + 1'b1;
    end
  end

  assign tick    = enable && (pcnt_q == PER_LAST);
  // Width 12+AVG_LOG2 holds 2^AVG_LOG2 full-scale samples, so the sum never wraps.
  assign acc_sum = acc_q + ACCW'(spi_d[11:0]);

`ifdef SPI_TIMEOUT_EN
  localparam int PHW = $clog2(TIMEOUT + 1);
  logic [PHW-1:0] ph_q;
  logic           err_q;
  logic           ph_expired;

  assign ph_expired = (ph_q == PHW'(TIMEOUT - 1));
  assign abort = ph_expired &&
                 (((state_q == REQ) && !rdy_s_q) || ((state_q == ACK) && rdy_s_q));

  always_ff @(posedge clk) begin
    if (rst) begin
      ph_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_d != state_q)                        ph_q <= '0;
      else if ((state_q == REQ) || (state_q == ACK)) ph_q <= ph_q + 1'b1;
      if (abort) err_q <= 1'b1;
    end
  end

  assign timeout_err = err_q;
`else
  localparam int TIMEOUT_UNUSED = TIMEOUT;
  assign abort       = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    spi_rd_d = spi_rd_q;
    sample_d = sample_q;
    sval_d   = 1'b0;
    avg_d    = avg_q;
    aval_d   = 1'b0;
    acc_d    = acc_q;
    scnt_d   = scnt_q;
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          state_d  = REQ;
          spi_rd_d = 1'b1;
        end
      end
      REQ: begin
        if (rdy_s_q) begin
          state_d = CAP;
        end else if (abort) begin
          state_d  = IDLE;
          spi_rd_d = 1'b0;
        end
      end
      CAP: begin
        state_d  = ACK;
        spi_rd_d = 1'b0;
        sample_d = spi_d[11:0];
        sval_d   = 1'b1;
        if (scnt_q == SCNT_LAST) begin
          avg_d  = acc_sum[AVG_LOG2 +: 12];
          aval_d = 1'b1;
          acc_d  = '0;
          scnt_d = '0;
        end else begin
          acc_d  = acc_sum;
          scnt_d = scnt_q + 1'b1;
        end
      end
      ACK: begin
        if (!rdy_s_q || abort) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      spi_rd_q <= 1'b0;
      sample_q <= '0;
      sval_q   <= 1'b0;
      avg_q    <= '0;
      aval_q   <= 1'b0;
      acc_q    <= '0;
      scnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      spi_rd_q <= spi_rd_d;
      sample_q <= sample_d;
      sval_q   <= sval_d;
      avg_q    <= avg_d;
      aval_q   <= aval_d;
      acc_q    <= acc_d;
      scnt_q   <= scnt_d;
    end
  end

  assign spi_rd       = spi_rd_q;
  assign sample       = sample_q;
  assign sample_valid = sval_q;
  assign avg          = avg_q;
  assign avg_valid    = aval_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_spi_sample_reader.sv
// Scoreboard bench for spi_sample_reader: a randomized SPI slave feeds frames, a block-average model
// predicts sample/avg values and latencies, and a monitor compares whenever the DUT pulses valid.
module tb_spi_sample_reader;
  localparam int PERIOD   = 16;
  localparam int AVG_LOG2 = 2;
  localparam int TIMEOUT  = 32;
  localparam int N_AVG    = 1 << AVG_LOG2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        spi_d_ready;
  logic [15:0] spi_d;
  logic        spi_rd;
  logic [11:0] sample;
  logic        sample_valid;
  logic [11:0] avg;
  logic        avg_valid;
  logic        busy;
  logic        timeout_err;

  spi_sample_reader #(.PERIOD(PERIOD), .AVG_LOG2(AVG_LOG2), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .spi_d_ready(spi_d_ready), .spi_d(spi_d), .spi_rd(spi_rd),
    .sample(sample), .sample_valid(sample_valid),
    .avg(avg), .avg_valid(avg_valid),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [11:0] samp_exp_q[$];
  int          exp_cyc_q[$];
  bit          avg_flag_q[$];
  logic [11:0] avg_exp_q[$];
  logic [15:0] data_q[$];
  int          dly_q[$];
  int          blk_sum = 0;
  int          blk_n = 0;
  int          nsamp = 0;
  int          ref_cyc = 0;
  bit          exact_next = 1'b0;
  bit          hold = 1'b0;
  bit          rel_ready = 1'b0;
  bit          rd_prev = 1'b0;

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endfunction

  // Reference: every frame contributes its low 12 bits; each full block of N_AVG yields floor(sum / N_AVG).
  function automatic void model_push(logic [15:0] d);
    samp_exp_q.push_back(d[11:0]);
    exp_cyc_q.push_back(cyc + 4);
    blk_sum += int'(d[11:0]);
    blk_n++;
    if (blk_n == N_AVG) begin
      avg_exp_q.push_back(12'(blk_sum / N_AVG));
      avg_flag_q.push_back(1'b1);
      blk_sum = 0;
      blk_n = 0;
    end else begin
      avg_flag_q.push_back(1'b0);
    end
  endfunction

  initial begin : slave
    logic [15:0] d;
    int dly, n;
    spi_d_ready = 1'b1;
    spi_d = 16'hFFFF;
    wait (rel_ready);
    spi_d_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (spi_rd && !hold && !rst) begin
        if (data_q.size() > 0) begin
          d = data_q.pop_front();
          dly = dly_q.pop_front();
        end else begin
          d = 16'($urandom);
          dly = $urandom_range(0, 4);
        end
        repeat (dly) @(posedge clk);
        #1;
        spi_d = d;
        spi_d_ready = 1'b1;
        model_push(d);
        n = 0;
        while (spi_rd && n < 64) begin
          @(posedge clk); #1;
          n++;
        end
        chk("slave_rd_released", n < 64, 1);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        spi_d_ready = 1'b0;
        spi_d = 16'($urandom);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (sample_valid) begin
        nsamp++;
        chk("sample_expected_pending", samp_exp_q.size() > 0, 1);
        if (samp_exp_q.size() > 0) begin
          chk("sample", sample, samp_exp_q.pop_front());
          chk("sample_latency_cycle", cyc, exp_cyc_q.pop_front());
          chk("spi_rd_low_at_capture", spi_rd, 0);
          chk("avg_valid_with_sample", avg_valid, avg_flag_q.pop_front());
        end
      end
      if (avg_valid) begin
        chk("avg_expected_pending", avg_exp_q.size() > 0, 1);
        if (avg_exp_q.size() > 0) chk("avg", avg, avg_exp_q.pop_front());
      end
      if (spi_rd && !rd_prev) begin
        if (exact_next) chk("req_first_after_anchor", cyc - ref_cyc, PERIOD);
        else            chk("req_spacing_multiple", (cyc - ref_cyc) % PERIOD, 0);
        exact_next = 1'b0;
        ref_cyc = cyc;
      end
    end
    rd_prev = spi_rd;
  end

  task automatic wait_samples(int n);
    int target;
    int lim;
    target = nsamp + n;
    lim = 0;
    while (nsamp < target && lim < n * 64) begin
      @(posedge clk);
      lim++;
    end
    chk("wait_samples_in_budget", nsamp >= target, 1);
  endtask

  task automatic wait_rd(logic level);
    int n;
    n = 0;
    while (spi_rd !== level && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_spi_rd_level", spi_rd, level);
  endtask

  initial begin : main
    int rise_c, n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_spi_rd", spi_rd, 0);
    chk("rst_sample", sample, 0);
    chk("rst_sample_valid", sample_valid, 0);
    chk("rst_avg", avg, 0);
    chk("rst_avg_valid", avg_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_err", timeout_err, 0);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("no_req_while_disabled", spi_rd, 0);
    chk("idle_while_disabled", busy, 0);
    rel_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    enable = 1'b1;
    ref_cyc = cyc;
    exact_next = 1'b1;

    foreach (data_q[i]) data_q.delete(i);
    data_q = '{16'h0010, 16'h0020, 16'h0030, 16'h0041,
               16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0ABC};
    dly_q  = '{1, 0, 3, 2, 4, 1, 0, 2, 20};
    wait_samples(12);
    wait_samples(20);

    // Reset while a request is outstanding.
    hold = 1'b1;
    wait_rd(1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("in_req_before_reset", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("spi_rd_low_on_reset_edge", spi_rd, 0);
    chk("idle_after_reset", busy, 0);
    blk_sum = 0;
    blk_n = 0;
    ref_cyc = cyc;
    exact_next = 1'b1;
    rst = 1'b0;
    hold = 1'b0;
    wait_samples(8);

`ifdef SPI_TIMEOUT_EN
    hold = 1'b1;
    wait_rd(1'b1);
    rise_c = cyc;
    n = 0;
    while (spi_rd && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("timeout_rd_width", cyc - rise_c, TIMEOUT);
    chk("timeout_err_set", timeout_err, 1);
    hold = 1'b0;
    wait_samples(4);
    chk("timeout_err_sticky", timeout_err, 1);
`else
    chk("timeout_err_tied_low", timeout_err, 0);
`endif

    @(posedge clk);
    #1;
    enable = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_idle", busy, 0);
    repeat (PERIOD * 2) @(posedge clk);
    #1;
    chk("no_req_after_disable", spi_rd, 0);
    chk("samples_outstanding", samp_exp_q.size(), 0);
    chk("avgs_outstanding", avg_exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_sample_reader.md
# spi_sample_reader

Application-side consumer for the SPI read engine. It periodically requests a 16-bit frame over the `rd`/`d_ready`/`d` handshake and extracts the 12-bit ADC sample. It publishes each sample and a block average of 2^AVG_LOG2 samples to downstream logic (display/UART). It runs on the system clock and synchronizes `d_ready`, which the SPI engine produces on its divided SCLK.

## Interface
- PERIOD, 100000: clk cycles between request starts; legal range ≥ 16.
- AVG_LOG2, 2: log2 of the number of samples averaged; legal range 0..8.
- TIMEOUT, 4096: clk cycles allowed per handshake phase before abort (only with SPI_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  enables periodic requests.
- spi_d_ready  in  1  from SPI engine; asynchronous to clk, double-flopped internally.
- spi_d  in  16  frame from SPI engine; stable while spi_d_ready is high.
- spi_rd  out  1  read request to SPI engine.
- sample  out  12  last captured sample, `spi_d[11:0]`.
- sample_valid  out  1  one-cycle pulse when `sample` updates.
- avg  out  12  last block average.
- avg_valid  out  1  one-cycle pulse when `avg` updates.
- busy  out  1  high whenever state ≠ IDLE.
- timeout_err  out  1  sticky handshake-timeout flag.

## Operation
- Reset values: spi_rd=0, sample=0, sample_valid=0, avg=0, avg_valid=0, busy=0, timeout_err=0. Reset also clears the FSM (to IDLE), period counter, accumulator, sample count, and sync flops.
- Period counter runs 0..PERIOD-1 while `enable`=1 and wraps. It is held at 0 while `enable`=0. `tick` is asserted at count PERIOD-1.
- `rdy_s` is the second flop of the spi_d_ready synchronizer.
- FSM:
  - IDLE: on `tick` go to REQ and set spi_rd=1.
  - REQ: when `rdy_s`=1 go to CAP.
  - CAP: register sample←spi_d[11:0], pulse sample_valid, clear spi_rd, update the accumulator, then go to ACK.
  - ACK: when `rdy_s`=0 return to IDLE.
- A `tick` arriving outside IDLE is dropped; there is no queueing.
- Dropping `enable` mid-transaction does not abort it; the current frame completes.
- spi_d[15:12] are ignored.
- Accumulator is 12+AVG_LOG2 bits wide with a sample counter.
  - On the 2^AVG_LOG2-th sample: avg ← (acc+sample) >> AVG_LOG2 (truncating), avg_valid pulses in the same cycle as sample_valid, and acc and counter clear.
  - Otherwise: acc ← acc+sample.
  - The accumulator cannot overflow.
- AVG_LOG2=0: avg equals sample and avg_valid pulses with every sample_valid.
- Reset mid-transaction: spi_rd drops at the reset edge. The SPI engine sees rd low and returns to its idle state unaided.

## Timing
- spi_rd rises on the clk edge after the cycle in which `tick`=1.
- sample_valid and avg_valid are registered, one cycle wide, and occur on the 4th rising clk edge after spi_d_ready rises: 2 sync flops, REQ detect, CAP register.
- spi_rd falls on that same edge.
- After spi_d_ready falls, the FSM reaches IDLE within 3 clk.
- Minimum request-to-request spacing is PERIOD cycles, provided the transaction completes within PERIOD.

## Configuration
- SPI_TIMEOUT_EN defined:
  - A phase counter clears on entry to REQ and to ACK and increments each cycle in those states.
  - At TIMEOUT: spi_rd←0, timeout_err←1 (sticky until rst), FSM→IDLE, no sample/avg update.
- SPI_TIMEOUT_EN undefined:
  - REQ and ACK wait indefinitely.
  - timeout_err is constant 0 and no counter logic is built.

## Test plan
- Reset with spi_d_ready=1, spi_d=16'hFFFF -> all outputs 0; spi_rd stays 0 until first tick.
- PERIOD=16, enable=1, slave model asserts spi_d_ready 20 clk after spi_rd with spi_d=16'h0ABC -> sample=12'hABC; sample_valid single pulse 4 edges after ready; spi_rd low on that edge.
- AVG_LOG2=2, frames 16'h0010, 16'h0020, 16'h0030, 16'h0041 -> avg_valid only on 4th sample; avg=12'h028 (0xA1>>2).
- AVG_LOG2=2, four frames 16'hFFFF -> avg=12'hFFF, no overflow.
- rst pulsed while in REQ, then released -> spi_rd low on the reset edge; next request only after a full PERIOD; accumulator restarts from 0.
- With SPI_TIMEOUT_EN, TIMEOUT=32, slave never asserts ready -> spi_rd drops after 32 cycles in REQ; timeout_err=1 and stays set; the next tick issues a new request.
